// File: rtl/average_pooling.sv
// Average-pools the 1-bit canvas into OUT_DIM x OUT_DIM OUT_W-bit features, one feature-RAM write per window.
// Build option: define AVG_POOL_THRESHOLD_EN to emit binarised features (all-ones when sum >= half window).
module average_pooling #(
  parameter int CANVAS_W = 224,
  parameter int POOL     = 8,
  parameter int OUT_W    = 8,
  localparam int OUT_DIM = CANVAS_W / POOL,
  localparam int PIX_AW  = $clog2(CANVAS_W * CANVAS_W),
  localparam int FEAT_AW = $clog2(OUT_DIM * OUT_DIM),
  localparam int SUM_W   = $clog2(POOL * POOL + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic               pix_rd_en,
  output logic [PIX_AW-1:0]  pix_rd_addr,
  input  logic               pix_rd_data,
  output logic               feat_wr_en,
  output logic [FEAT_AW-1:0] feat_wr_addr,
  output logic [OUT_W-1:0]   feat_wr_data
);
  localparam int WIN      = POOL * POOL;
  localparam int LOG2_WIN = $clog2(WIN);
  localparam int SHIFT    = OUT_W - LOG2_WIN;
  localparam int CW       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int DW       = (POOL > 1) ? $clog2(POOL) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(OUT_DIM - 1);
  localparam logic [DW-1:0] LAST_D   = DW'(POOL - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic [DW-1:0]    dx;
  logic [DW-1:0]    dy;
  logic             vld_p1;
  logic [SUM_W-1:0] sum_p1;

`ifdef AVG_POOL_THRESHOLD_EN
  function automatic logic [OUT_W-1:0] pool_scale(input logic [SUM_W-1:0] s);
    return (s >= SUM_W'(WIN / 2)) ? '1 : '0;
  endfunction
`else
  function automatic logic [OUT_W-1:0] pool_scale(input logic [SUM_W-1:0] s);
    logic [SUM_W+OUT_W-1:0] wide;
    wide = {{OUT_W{1'b0}}, s} << SHIFT;
    if (wide > {{SUM_W{1'b0}}, {OUT_W{1'b1}}})
      return '1;
    return wide[OUT_W-1:0];
  endfunction
`endif

  // p0: read request for (col*POOL+dx, row*POOL+dy); p1: returned pixel accumulated under vld_p1
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      dx     <= '0;
      dy     <= '0;
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
    end else if (en) begin
      vld_p1 <= (state == S_READ);
      if (vld_p1)
        sum_p1 <= sum_p1 + SUM_W'(pix_rd_data);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_READ;
            col    <= '0;
            row    <= '0;
            dx     <= '0;
            dy     <= '0;
            sum_p1 <= '0;
          end
        end
        S_READ: begin
          if (dx == LAST_D) begin
            dx <= '0;
            if (dy == LAST_D) begin
              dy    <= '0;
              state <= S_DRAIN;
            end else begin
              dy <= dy + 1'b1;
            end
          end else begin
            dx <= dx + 1'b1;
          end
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          sum_p1 <= '0;
          state  <= S_READ;
          if (col == LAST_IDX) begin
            col <= '0;
            if (row == LAST_IDX) begin
              row   <= '0;
              state <= S_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by en so a frozen cycle never issues a read or repeats a write
  assign busy         = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
  assign done         = (state == S_DONE);
  assign pix_rd_en    = en && (state == S_READ);
  assign feat_wr_en   = en && (state == S_WRITE);
  assign pix_rd_addr  = (PIX_AW'(row) * PIX_AW'(POOL) + PIX_AW'(dy)) * PIX_AW'(CANVAS_W)
                      + PIX_AW'(col) * PIX_AW'(POOL) + PIX_AW'(dx);
  assign feat_wr_addr = FEAT_AW'(row) * FEAT_AW'(OUT_DIM) + FEAT_AW'(col);
  assign feat_wr_data = pool_scale(sum_p1);

endmodule

// File: tb/tb_average_pooling.sv
// Bench for average_pooling on a reduced 32x32 canvas, 4x4 windows, 6-bit features.
module tb_average_pooling;
  localparam int CANVAS_W = 32;
  localparam int POOL     = 4;
  localparam int OUT_W    = 6;
  localparam int OUT_DIM  = CANVAS_W / POOL;
  localparam int PIX_AW   = $clog2(CANVAS_W * CANVAS_W);
  localparam int FEAT_AW  = $clog2(OUT_DIM * OUT_DIM);
  localparam int WIN      = POOL * POOL;
  localparam int LAT      = OUT_DIM * OUT_DIM * (WIN + 2);
  localparam int MAXV     = (1 << OUT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic               start = 1'b0;
  logic               done;
  logic               busy;
  logic               pix_rd_en;
  logic [PIX_AW-1:0]  pix_rd_addr;
  logic               pix_rd_data = 1'b0;
  logic               feat_wr_en;
  logic [FEAT_AW-1:0] feat_wr_addr;
  logic [OUT_W-1:0]   feat_wr_data;

  bit canvas [CANVAS_W*CANVAS_W];
  int exp_addr_q[$];
  int exp_data_q[$];
  int errors = 0;
  int checks = 0;
  int writes = 0;

  average_pooling #(.CANVAS_W(CANVAS_W), .POOL(POOL), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .done(done), .busy(busy),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .feat_wr_en(feat_wr_en), .feat_wr_addr(feat_wr_addr), .feat_wr_data(feat_wr_data)
  );

  always #5 clk = ~clk;

  // Frame memory: data one cycle after an issued read, held otherwise
  always @(posedge clk)
    if (pix_rd_en) pix_rd_data <= canvas[pix_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_val(input int s);
`ifdef AVG_POOL_THRESHOLD_EN
    return (s >= WIN / 2) ? MAXV : 0;
`else
    int v;
    v = s * (1 << (OUT_W - $clog2(WIN)));
    return (v > MAXV) ? MAXV : v;
`endif
  endfunction

  // Write monitor / scoreboard pop
  always @(negedge clk) begin
    if (!en) begin
      checks++;
      assert (feat_wr_en === 1'b0 && pix_rd_en === 1'b0) else begin
        errors++;
        $error("FAIL strobe_while_en_low wr=%0b rd=%0b expected 0", feat_wr_en, pix_rd_en);
      end
    end
    if (feat_wr_en === 1'b1) begin
      writes++;
      checks++;
      assert (exp_addr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write addr=%0d data=%0d expected none", feat_wr_addr, feat_wr_data);
      end
      if (exp_addr_q.size() != 0) begin
        int ea;
        int ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        checks += 2;
        assert (int'(feat_wr_addr) === ea) else begin
          errors++;
          $error("FAIL wr_addr observed=%0d expected=%0d", feat_wr_addr, ea);
        end
        assert (int'(feat_wr_data) === ed) else begin
          errors++;
          $error("FAIL wr_data addr=%0d observed=%0d expected=%0d", ea, feat_wr_data, ed);
        end
      end
    end
  end

  task automatic fill(input int pattern);
    for (int y = 0; y < CANVAS_W; y++)
      for (int x = 0; x < CANVAS_W; x++)
        case (pattern)
          0: canvas[y*CANVAS_W+x] = 1'b0;
          1: canvas[y*CANVAS_W+x] = 1'b1;
          2: canvas[y*CANVAS_W+x] = (x == POOL && y == 0);
          default: canvas[y*CANVAS_W+x] = ((x + y) % 2 == 1);
        endcase
  endtask

  task automatic do_start();
    for (int r = 0; r < OUT_DIM; r++)
      for (int c = 0; c < OUT_DIM; c++) begin
        int s;
        s = 0;
        for (int dy = 0; dy < POOL; dy++)
          for (int dx = 0; dx < POOL; dx++)
            s += int'(canvas[(r*POOL+dy)*CANVAS_W + c*POOL + dx]);
        exp_addr_q.push_back(r * OUT_DIM + c);
        exp_data_q.push_back(exp_val(s));
      end
    writes = 0;
    start = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  task automatic run_wait(input bit rand_en, input int stray_at, input string tag);
    int edges;
    bit got;
    edges = 0;
    got = 1'b0;
    for (int i = 0; i < 4 * LAT && !got; i++) begin
      en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = (i == stray_at);
      @(posedge clk);
      if (en) edges++;
      #1;
      got = done;
    end
    start = 1'b0;
    en = 1'b1;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, edges, LAT);
    check({tag, "_write_count"}, writes, OUT_DIM * OUT_DIM);
    check({tag, "_queue_left"}, exp_addr_q.size(), 0);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, pix_rd_en, 0);
    check({tag, "_wr_en"}, feat_wr_en, 0);
    check({tag, "_rd_addr"}, pix_rd_addr, 0);
    check({tag, "_wr_addr"}, feat_wr_addr, 0);
    check({tag, "_wr_data"}, feat_wr_data, 0);
  endtask

  initial begin
    // Reset with en low: reset must still win
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // start while en low is ignored
    start = 1'b1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    en = 1'b1;
    check("start_en_low_busy", busy, 0);
    check("start_en_low_done", done, 0);

    fill(0);
    do_start();
    run_wait(1'b0, -1, "zero");

    fill(1);
    do_start();
    run_wait(1'b0, -1, "ones");
    repeat (5) @(posedge clk);
    #1;
    check("done_held", done, 1);
    check("busy_held_low", busy, 0);

    fill(2);
    do_start();
    run_wait(1'b0, -1, "single");

    fill(3);
    do_start();
    run_wait(1'b0, -1, "checker");

    // Random en plus a stray start mid-run
    fill(3);
    do_start();
    run_wait(1'b1, 100, "rand_en");

    // Reset mid-run, then a clean run
    fill(3);
    do_start();
    repeat (300) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("midrun_reset");
    exp_addr_q.delete();
    exp_data_q.delete();
    writes = 0;
    repeat (50) @(posedge clk);
    #1;
    check("post_reset_no_writes", writes, 0);
    check("post_reset_busy", busy, 0);

    fill(1);
    do_start();
    run_wait(1'b0, -1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
